// File: rtl/sched_type_lookup_if.sv
// ----------------------------------------------------------------------------
// sched_type_lookup_if
// Request/response handshake between the task-dispatch front end and the
// scheduling-table lookup block.
//
//   req_valid      front end -> lookup   lookup request valid
//   req_ready      lookup -> front end   lookup can accept a request
//   req_task_type  front end -> lookup   task type to look up
//   resp_valid     lookup -> front end   response valid
//   resp_ready     front end -> lookup   consumer accepts response
//   resp_found     lookup -> front end   1 = hit, 0 = miss
//   resp_acc_id    lookup -> front end   selected accelerator ID, 0 on miss
//
// master: the front end issuing requests.  slave: the lookup block.
// ----------------------------------------------------------------------------
interface sched_type_lookup_if #(
    parameter int unsigned ACC_BITS = 4,
    parameter int unsigned TYPE_W   = 34
);
    logic                req_valid;
    logic                req_ready;
    logic [TYPE_W-1:0]   req_task_type;
    logic                resp_valid;
    logic                resp_ready;
    logic                resp_found;
    logic [ACC_BITS-1:0] resp_acc_id;

    modport master (
        output req_valid,
        output req_task_type,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_found,
        input  resp_acc_id
    );

    modport slave (
        input  req_valid,
        input  req_task_type,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_found,
        output resp_acc_id
    );
endinterface

// File: rtl/sched_type_lookup.sv
// ----------------------------------------------------------------------------
// sched_type_lookup
// Read-side consumer of the scheduling data memory filled by the bitinfo
// parser at boot.  For each lookup request it scans the table (memory port B)
// from address 0 for an entry whose task type matches, and answers with an
// accelerator ID picked round-robin among that type's instances, or a miss.
// A zero task type in the table marks the end of the table.
//
// Ports:
//   clk         clock
//   rstn        synchronous active-low reset
//   lk          request/response handshake (sched_type_lookup_if.slave)
//   sched_addr  port B address
//   sched_en    port B read enable (data returns one cycle later)
//   sched_dout  port B read data: accid, count (instances-1), task type
//
// Build option: define SCHED_LOOKUP_CACHE_EN to add a one-entry cache of the
// last hit {task type, table address}; a request that hits the cache reads
// the cached address directly instead of scanning from address 0.
// ----------------------------------------------------------------------------
module sched_type_lookup #(
    parameter  int unsigned MAX_ACCS = 16,
    localparam int unsigned ACC_BITS = $clog2(MAX_ACCS)
) (
    input  logic                  clk,
    input  logic                  rstn,
    sched_type_lookup_if.slave    lk,
    output logic [ACC_BITS-1:0]   sched_addr,
    output logic                  sched_en,
    input  logic [49:0]           sched_dout
);

    // Scheduling data word layout
    localparam int unsigned TYPE_W                 = 34;
    localparam int unsigned DATA_W                 = 50;
    localparam int unsigned SCHED_DATA_ACCID_L     = 0;
    localparam int unsigned SCHED_DATA_COUNT_L     = 8;
    localparam int unsigned SCHED_DATA_TASK_TYPE_L = 16;
    localparam int unsigned SCHED_DATA_TASK_TYPE_H = 49;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CHECK,
        RESP
    } state_t;

    // Registered state and outputs
    state_t              state_q;
    logic [TYPE_W-1:0]   type_q;
    logic [ACC_BITS-1:0] addr_q;
    logic                sched_en_q;
    logic                req_ready_q;
    logic                resp_valid_q;
    logic                resp_found_q;
    logic [ACC_BITS-1:0] resp_acc_id_q;
    logic [ACC_BITS-1:0] rr_q [MAX_ACCS];

    // Next-state values
    state_t              state_d;
    logic [TYPE_W-1:0]   type_d;
    logic [ACC_BITS-1:0] addr_d;
    logic                sched_en_d;
    logic                req_ready_d;
    logic                resp_valid_d;
    logic                resp_found_d;
    logic [ACC_BITS-1:0] resp_acc_id_d;
    logic                rr_we;
    logic [ACC_BITS-1:0] rr_wdata;

    // Fields of the word currently on port B
    logic [TYPE_W-1:0]   dout_type;
    logic [ACC_BITS-1:0] dout_accid;
    logic [ACC_BITS-1:0] dout_count;
    logic [ACC_BITS-1:0] rr_cur;
    logic                last_addr;
    logic                accept;

    // Bits of the data word outside the fields used here
    logic [DATA_W-1:0]   unused_dout;

    assign dout_type   = sched_dout[SCHED_DATA_TASK_TYPE_H:SCHED_DATA_TASK_TYPE_L];
    assign dout_accid  = sched_dout[SCHED_DATA_ACCID_L +: ACC_BITS];
    assign dout_count  = sched_dout[SCHED_DATA_COUNT_L +: ACC_BITS];
    assign unused_dout = sched_dout;
    assign rr_cur      = rr_q[addr_q];
    assign last_addr   = (addr_q == ACC_BITS'(MAX_ACCS - 1));
    assign accept      = lk.req_valid && req_ready_q;

`ifdef SCHED_LOOKUP_CACHE_EN
    // Last-hit cache
    logic                cache_valid_q;
    logic [TYPE_W-1:0]   cache_type_q;
    logic [ACC_BITS-1:0] cache_addr_q;
    logic                cache_we;
    logic                cache_hit;

    assign cache_hit = cache_valid_q && (cache_type_q == lk.req_task_type);
`endif

    // Next-state and output decode
    always_comb begin
        state_d       = state_q;
        type_d        = type_q;
        addr_d        = addr_q;
        resp_found_d  = resp_found_q;
        resp_acc_id_d = resp_acc_id_q;
        rr_we         = 1'b0;
        // Round-robin step: wrap after the last instance of this type
        rr_wdata      = (rr_cur == dout_count) ? '0 : rr_cur + ACC_BITS'(1);
`ifdef SCHED_LOOKUP_CACHE_EN
        cache_we      = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    type_d  = lk.req_task_type;
                    addr_d  = '0;
`ifdef SCHED_LOOKUP_CACHE_EN
                    if (cache_hit) begin
                        addr_d = cache_addr_q;
                    end
`endif
                    state_d = READ;
                end
            end

            READ: begin
                state_d = CHECK;
            end

            CHECK: begin
                if (dout_type == type_q) begin
                    resp_found_d  = 1'b1;
                    resp_acc_id_d = dout_accid + rr_cur;
                    rr_we         = 1'b1;
`ifdef SCHED_LOOKUP_CACHE_EN
                    cache_we      = 1'b1;
`endif
                    state_d       = RESP;
                end else if ((dout_type == '0) || last_addr) begin
                    resp_found_d  = 1'b0;
                    resp_acc_id_d = '0;
                    state_d       = RESP;
                end else begin
                    addr_d  = addr_q + ACC_BITS'(1);
                    state_d = READ;
                end
            end

            RESP: begin
                if (lk.resp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the state being entered
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
        sched_en_d   = (state_d == READ);
    end

    // State, output and round-robin registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= IDLE;
            type_q        <= '0;
            addr_q        <= '0;
            sched_en_q    <= 1'b0;
            req_ready_q   <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_found_q  <= 1'b0;
            resp_acc_id_q <= '0;
            for (int i = 0; i < MAX_ACCS; i++) begin
                rr_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            type_q        <= type_d;
            addr_q        <= addr_d;
            sched_en_q    <= sched_en_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_found_q  <= resp_found_d;
            resp_acc_id_q <= resp_acc_id_d;
            if (rr_we) begin
                rr_q[addr_q] <= rr_wdata;
            end
        end
    end

`ifdef SCHED_LOOKUP_CACHE_EN
    // Cache is loaded only on a hit
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cache_valid_q <= 1'b0;
            cache_type_q  <= '0;
            cache_addr_q  <= '0;
        end else if (cache_we) begin
            cache_valid_q <= 1'b1;
            cache_type_q  <= type_q;
            cache_addr_q  <= addr_q;
        end
    end
`endif

    assign lk.req_ready   = req_ready_q;
    assign lk.resp_valid  = resp_valid_q;
    assign lk.resp_found  = resp_found_q;
    assign lk.resp_acc_id = resp_acc_id_q;
    assign sched_addr     = addr_q;
    assign sched_en       = sched_en_q;

endmodule

// File: tb/tb_sched_type_lookup.sv
// ----------------------------------------------------------------------------
// tb_sched_type_lookup
// Self-checking bench for sched_type_lookup.  A behavioural table model
// predicts each response (hit/miss, accelerator ID, latency) at request
// acceptance; one compare process checks the DUT every cycle against it.
// Directed scenarios also pin a few literal values, followed by random tables
// and requests with random response back-pressure.
// ----------------------------------------------------------------------------
module tb_sched_type_lookup;

    localparam int unsigned MAX_ACCS = 16;
    localparam int unsigned ACC_BITS = 4;
    localparam int unsigned TYPE_W   = 34;
    localparam int unsigned DATA_W   = 50;
    localparam logic [TYPE_W-1:0] T_BIG = 34'd1000000017;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sched_type_lookup_if #(.ACC_BITS(ACC_BITS), .TYPE_W(TYPE_W)) lk ();

    logic [ACC_BITS-1:0] sched_addr;
    logic                sched_en;
    logic [DATA_W-1:0]   sched_dout = '0;

    sched_type_lookup #(.MAX_ACCS(MAX_ACCS)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .lk         (lk),
        .sched_addr (sched_addr),
        .sched_en   (sched_en),
        .sched_dout (sched_dout)
    );

    // Table contents (shared by the memory and the model)
    logic [TYPE_W-1:0] t_type  [MAX_ACCS];
    int                t_accid [MAX_ACCS];
    int                t_count [MAX_ACCS];

    // Port B memory, one-cycle read latency
    always @(posedge clk) begin
        if (sched_en)
            sched_dout <= {t_type[sched_addr], 8'(t_count[sched_addr]), 8'(t_accid[sched_addr])};
    end

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic   found;
        int     acc;
        int     lat;
        longint acc_cyc;
    } exp_t;

    exp_t   q[$];
    int     m_rr [MAX_ACCS];
    bit     mc_valid;
    logic [TYPE_W-1:0] mc_type;
    int     mc_idx;

    // Observed values of the last completed response
    int     last_acc;
    int     last_found;
    longint last_lat;
    longint rise_lat;
    bit     prev_valid;

    task automatic model_accept(input logic [TYPE_W-1:0] typ, output exp_t e);
        int idx;
        int n;
        idx = -1;
        n = MAX_ACCS;
        e.acc_cyc = cyc;
`ifdef SCHED_LOOKUP_CACHE_EN
        if (mc_valid && mc_type == typ) begin
            idx = mc_idx;
            e.lat = 3;
        end else
`endif
        begin
            for (int i = 0; i < MAX_ACCS; i++) begin
                if (t_type[i] == typ) begin idx = i; break; end
                if (t_type[i] == '0) begin n = i + 1; break; end
            end
            e.lat = (idx >= 0) ? 3 + 2 * idx : 1 + 2 * n;
        end
        if (idx >= 0) begin
            e.found = 1'b1;
            e.acc = (t_accid[idx] + m_rr[idx]) % MAX_ACCS;
            m_rr[idx] = (m_rr[idx] == t_count[idx]) ? 0 : m_rr[idx] + 1;
            mc_valid = 1'b1;
            mc_type = typ;
            mc_idx = idx;
        end else begin
            e.found = 1'b0;
            e.acc = 0;
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            q.delete();
            for (int i = 0; i < MAX_ACCS; i++) m_rr[i] = 0;
            mc_valid = 1'b0;
            prev_valid = 1'b0;
            chk("resp_valid_in_reset", 64'(lk.resp_valid), 64'd0);
        end else begin
            if (q.size() != 0 && !lk.resp_valid)
                chk("req_ready_while_busy", 64'(lk.req_ready), 64'd0);
            if (lk.resp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp_valid", 64'(lk.resp_valid), 64'd0);
                end else begin
                    e = q[0];
                    chk("resp_found", 64'(lk.resp_found), 64'(e.found));
                    chk("resp_acc_id", 64'(lk.resp_acc_id), 64'(e.acc));
                    chk("req_ready_in_resp", 64'(lk.req_ready), 64'd0);
                    if (!prev_valid) begin
                        rise_lat = cyc - e.acc_cyc;
                        chk("latency", 64'(rise_lat), 64'(e.lat));
                    end
                    if (lk.resp_ready) begin
                        last_acc = int'(lk.resp_acc_id);
                        last_found = int'(lk.resp_found);
                        last_lat = rise_lat;
                        void'(q.pop_front());
                    end
                end
            end
            if (lk.req_valid && lk.req_ready) begin
                model_accept(lk.req_task_type, e);
                q.push_back(e);
            end
            prev_valid = lk.resp_valid;
        end
    end

    // ---------------- driver helpers (called at posedge + 1) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [TYPE_W-1:0] typ, output bit ok);
        int guard;
        guard = 0;
        ok = 1'b1;
        while (!lk.req_ready && guard < 100) begin tick(); guard++; end
        if (!lk.req_ready) begin
            chk("req_ready_timeout", 64'(lk.req_ready), 64'd1);
            ok = 1'b0;
        end else begin
            lk.req_valid = 1'b1;
            lk.req_task_type = typ;
            tick();
            lk.req_valid = 1'b0;
        end
    endtask

    task automatic do_req(input logic [TYPE_W-1:0] typ, input int hold);
        bit ok;
        int guard;
        last_acc = -1;
        last_found = -1;
        last_lat = -1;
        send_req(typ, ok);
        if (ok) begin
            guard = 0;
            while (!lk.resp_valid && guard < 60) begin tick(); guard++; end
            if (!lk.resp_valid) begin
                chk("resp_valid_timeout", 64'(lk.resp_valid), 64'd1);
            end else begin
                repeat (hold) tick();
                lk.resp_ready = 1'b1;
                tick();
                lk.resp_ready = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic clear_table();
        for (int i = 0; i < MAX_ACCS; i++) begin
            t_type[i] = '0;
            t_accid[i] = 0;
            t_count[i] = 0;
        end
    endtask

    task automatic lit(input string name, input longint got, input longint exp);
        chk(name, 64'(got), 64'(exp));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        int len;
        int exp_second_lat;

        lk.req_valid = 1'b0;
        lk.req_task_type = '0;
        lk.resp_ready = 1'b0;
        clear_table();
        t_type[0] = T_BIG; t_accid[0] = 0; t_count[0] = 2;
        t_type[1] = 34'd5; t_accid[1] = 3; t_count[1] = 0;

        // Reset values
        rstn = 1'b0;
        repeat (3) tick();
        lit("rst_req_ready", lk.req_ready, 0);
        lit("rst_resp_valid", lk.resp_valid, 0);
        lit("rst_resp_found", lk.resp_found, 0);
        lit("rst_resp_acc_id", lk.resp_acc_id, 0);
        lit("rst_sched_en", sched_en, 0);
        lit("rst_sched_addr", sched_addr, 0);
        rstn = 1'b1;
        lit("req_ready_at_release", lk.req_ready, 0);
        tick();
        lit("req_ready_after_release", lk.req_ready, 1);

        // Round-robin across three instances
        do_req(T_BIG, 0); lit("big1_acc", last_acc, 0); lit("big1_found", last_found, 1);
        lit("big1_lat", last_lat, 3);
        do_req(T_BIG, 0); lit("big2_acc", last_acc, 1);
        do_req(T_BIG, 0); lit("big3_acc", last_acc, 2);
        do_req(T_BIG, 0); lit("big4_acc", last_acc, 0); lit("big4_found", last_found, 1);

        // Single instance type
`ifdef SCHED_LOOKUP_CACHE_EN
        exp_second_lat = 3;
`else
        exp_second_lat = 5;
`endif
        do_req(34'd5, 0); lit("t5a_acc", last_acc, 3); lit("t5a_lat", last_lat, 5);
        do_req(34'd5, 0); lit("t5b_acc", last_acc, 3); lit("t5b_lat", last_lat, exp_second_lat);

        // Miss at end-of-table marker
        do_req(34'd42, 0); lit("miss_found", last_found, 0); lit("miss_acc", last_acc, 0);
        lit("miss_lat", last_lat, 7);

        // Long back-pressure on a hit: rr advances once
        do_req(T_BIG, 10); lit("stall_acc", last_acc, 1);
        do_req(T_BIG, 0); lit("after_stall_acc", last_acc, 2);
        do_req(T_BIG, 0); lit("wrap_acc", last_acc, 0);

        // Reset during CHECK of entry 1
        send_req(34'd5, ok);
        if (ok) begin
            repeat (3) tick();
            lit("midscan_addr", sched_addr, 1);
            rstn = 1'b0;
            repeat (3) begin tick(); lit("midscan_no_resp", lk.resp_valid, 0); end
            rstn = 1'b1;
            repeat (3) begin tick(); lit("post_reset_no_resp", lk.resp_valid, 0); end
        end
        do_req(T_BIG, 0); lit("post_reset_acc", last_acc, 0);

        // Fully populated table, no terminator
        for (int i = 0; i < MAX_ACCS; i++) begin
            t_type[i] = TYPE_W'(100 + i); t_accid[i] = i; t_count[i] = 0;
        end
        do_reset();
        do_req(34'd42, 0); lit("full_miss_found", last_found, 0); lit("full_miss_lat", last_lat, 33);
        do_req(34'd107, 0); lit("full_hit_acc", last_acc, 7); lit("full_hit_lat", last_lat, 17);
        do_req(34'd115, 0); lit("last_entry_acc", last_acc, 15);

        // Random tables and requests
        for (int r = 0; r < 6; r++) begin
            clear_table();
            len = $urandom_range(1, MAX_ACCS);
            for (int i = 0; i < len; i++) begin
                t_type[i] = TYPE_W'($urandom_range(1, 20));
                if ($urandom_range(0, 7) == 0) t_type[i] = {$urandom_range(1, 3), 32'($urandom)} | 34'd1;
                t_accid[i] = $urandom_range(0, MAX_ACCS - 1);
                t_count[i] = $urandom_range(0, 3);
            end
            do_reset();
            for (int k = 0; k < 25; k++)
                do_req(TYPE_W'($urandom_range(1, 24)), $urandom_range(0, 3));
        end

        repeat (3) tick();
        lit("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
